dijkstra_relax_unit: RTL
========================

Name: dijkstra_relax_unit

Overview:
Control and relaxation stage of the float Dijkstra engine. It owns the distance, visited and predecessor state that the min-heap block reads, and it consumes the heap's selected minimum. Each iteration it marks that node visited, streams the node's adjacency row from a synchronous memory, and relaxes neighbour distances using the team's fp_adder and fp_comparator. It then notifies the heap to recompute.

Parameters:
MAX_NODES, 8, node count; must equal 2**INDEX_WIDTH
INDEX_WIDTH, 3, node index width
VALUE_WIDTH, 32, IEEE-754 single-precision distance/weight width
INF, 32'h7F800000, "no edge" / unreached distance
SETTLE_CYCLES, 4, cycles to wait after min_ready rises before sampling min_index/min_value

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse; begins a search
source_index  in  INDEX_WIDTH  search origin, sampled on start
target_index  in  INDEX_WIDTH  search goal, sampled on start
min_ready  in  1  heap result valid
min_index  in  INDEX_WIDTH  heap-selected node
min_value  in  VALUE_WIDTH  distance of min_index
adj_rd_en  out  1  adjacency read strobe
adj_addr  out  2*INDEX_WIDTH  {row u, column j}
adj_rd_data  in  VALUE_WIDTH  edge weight u->j; valid one cycle after adj_rd_en; INF means no edge
dist_vector  out  VALUE_WIDTH x MAX_NODES  unpacked array, current distances
visited_vector  out  MAX_NODES  1 = visited, 0 = unvisited
prev_vector  out  INDEX_WIDTH x MAX_NODES  unpacked array, predecessors
set_en  out  1  one-cycle pulse after init; heap restart
visit_vector_true  out  1  one-cycle pulse after each relaxation pass; heap restart
busy  out  1  high from accepted start until DONE
done  out  1  high in DONE until next accepted start
unreachable  out  1  valid with done; target not reached

Behaviour:
- Reset values: dist all INF, visited 0, prev 0, all pulses/flags/adj_rd_en 0, adj_addr 0, state IDLE.
- IDLE: start latches src/tgt and goes to INIT. If src or tgt >= MAX_NODES, go directly to DONE with unreachable=1, with no state change.
- INIT, 1 cycle: dist=INF except dist[src]=0; visited=0; prev[k]=k; set_en=1 this cycle. Next state is WAIT_MIN.
- WAIT_MIN: ignore min_ready in the first cycle. After that, min_ready=1 loads the counter with SETTLE_CYCLES and moves to SETTLE.
- SETTLE: decrement the counter; at 0 go to SELECT. min_ready falling during SETTLE returns to WAIT_MIN.
- SELECT, 1 cycle: latch u=min_index, du=min_value.
  - If du==INF or visited[u]==1: go to DONE with unreachable = ~visited[tgt].
  - Else set visited[u]=1.
  - If u==tgt: go to DONE with unreachable=0.
  - Otherwise set j=0 and go to READ.
- READ, 1 cycle: adj_rd_en=1, adj_addr={u,j}. Go to RELAX.
- RELAX, 1 cycle: sum = fp_adder(du, adj_rd_data). Update when j!=u, visited[j]==0, adj_rd_data!=INF, and fp_comparator lt(sum, dist[j])==1 (strict). On update: dist[j]<=sum, prev[j]<=u. If j==MAX_NODES-1 go to NOTIFY; else j++ and go to READ.
- NOTIFY, 1 cycle: visit_vector_true=1. Go to WAIT_MIN.
- Timing: 2 cycles per neighbour; one iteration = 1 + 2*MAX_NODES + 1 cycles plus heap wait.
- DONE: busy=0, done=1. dist, visited and prev hold until next start.
- start while busy: ignored. start in DONE: accepted and clears done/unreachable.
- reset in any state: immediate return to reset values, including mid-RELAX (no partial write lands).
- Equal distance (sum == dist[j]) never updates. A self-edge u->u is never applied.
- NaN weights: fp_comparator returns lt=0, so no update.

Test Plan:
- Setup: MAX_NODES=4, INDEX_WIDTH=2. Bench uses the real heap or a behavioural model. Edges: 0->1=3F800000, 0->2=40800000, 1->2=40000000, 2->3=3F800000; all other entries INF.
- src 0, tgt 3 -> done=1, unreachable=0; dist={0,3F800000,40400000,40800000}; prev[3]=2, prev[2]=1, prev[1]=0; 3 visit_vector_true pulses.
- Same graph with edge 2->3 set to INF, src 0, tgt 3 -> done=1, unreachable=1, dist[3]=7F800000, visited=4'b0111.
- src 2, tgt 2 -> done after first SELECT; no adj_rd_en pulses; dist[2]=0, visited=4'b0100.
- Tie case: set 0->2 to 40400000, src 0, tgt 3 -> prev[2] stays 0, because 1->2 gives an equal sum and equality never updates.
- Assert reset during the second RELAX -> next cycle state IDLE, dist all 7F800000, visited=0, busy=0, done=0.
- start pulsed while busy -> ignored and result unchanged. start with tgt=3, src=3 after DONE -> accepted. On a MAX_NODES=8 build, src=7 with no outgoing edges -> done with unreachable=1 after 8 neighbour reads.

Source files
------------

// File: rtl/dijkstra_relax_unit.sv
`default_nettype none
// ============================================================================
//  Module   : dijkstra_relax_unit
//  Brief    : Control and edge-relaxation stage of the float Dijkstra engine.
//             Owns the distance, visited and predecessor state. It consumes the
//             heap's selected minimum and streams that node's adjacency row
//             from a synchronous memory. Neighbours are relaxed with an
//             IEEE-754 single-precision adder and less-than comparator.
//  Revision : 1.0 - initial release
// ============================================================================
module dijkstra_relax_unit #(
  parameter int                     MAX_NODES     = 8,
  parameter int                     INDEX_WIDTH   = 3,
  parameter int                     VALUE_WIDTH   = 32,
  parameter logic [VALUE_WIDTH-1:0] INF           = 32'h7F800000,
  parameter int                     SETTLE_CYCLES = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [INDEX_WIDTH-1:0]   source_index,
  input  logic [INDEX_WIDTH-1:0]   target_index,
  input  logic                     min_ready,
  input  logic [INDEX_WIDTH-1:0]   min_index,
  input  logic [VALUE_WIDTH-1:0]   min_value,
  output logic                     adj_rd_en,
  output logic [2*INDEX_WIDTH-1:0] adj_addr,
  input  logic [VALUE_WIDTH-1:0]   adj_rd_data,
  output logic [VALUE_WIDTH-1:0]   dist_vector [MAX_NODES],
  output logic [MAX_NODES-1:0]     visited_vector,
  output logic [INDEX_WIDTH-1:0]   prev_vector [MAX_NODES],
  output logic                     set_en,
  output logic                     visit_vector_true,
  output logic                     busy,
  output logic                     done,
  output logic                     unreachable
);

  localparam int CNT_WIDTH = $clog2(SETTLE_CYCLES + 1);
  localparam logic [INDEX_WIDTH-1:0] LAST_NODE = INDEX_WIDTH'(MAX_NODES - 1);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_INIT     = 4'd1,
    ST_WAIT_MIN = 4'd2,
    ST_SETTLE   = 4'd3,
    ST_SELECT   = 4'd4,
    ST_READ     = 4'd5,
    ST_RELAX    = 4'd6,
    ST_NOTIFY   = 4'd7,
    ST_DONE     = 4'd8
  } state_t;

  // Single-precision add, round-to-nearest-even, with NaN/Inf/denormal
  // handling. The arithmetic assumes VALUE_WIDTH is 32.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    logic [7:0]  ex, ey;
    logic [23:0] mx, my;
    logic [26:0] big, small_sh;
    logic [53:0] wide;
    logic [8:0]  diff;
    logic [27:0] r;
    logic [9:0]  e;
    logic [24:0] m;
    logic        rnd;
    if (a[30:23] == 8'hFF && a[22:0] != 23'd0) return a | 32'h0040_0000;
    if (b[30:23] == 8'hFF && b[22:0] != 23'd0) return b | 32'h0040_0000;
    if (a[30:23] == 8'hFF) begin
      if (b[30:23] == 8'hFF && a[31] != b[31]) return 32'h7FC0_0000;
      return a;
    end
    if (b[30:23] == 8'hFF) return b;
    // Order operands by magnitude so the difference path never goes negative.
    if (a[30:0] >= b[30:0]) begin x = a; y = b; end
    else                    begin x = b; y = a; end
    ex = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
    ey = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
    mx = {x[30:23] != 8'd0, x[22:0]};
    my = {y[30:23] != 8'd0, y[22:0]};
    diff = {1'b0, ex} - {1'b0, ey};
    if (diff > 9'd27) diff = 9'd27;
    // Align the smaller operand, folding shifted-out bits into a sticky bit.
    wide        = {my, 3'b000, 27'd0} >> diff;
    small_sh    = wide[53:27];
    small_sh[0] = small_sh[0] | (|wide[26:0]);
    big         = {mx, 3'b000};
    if (x[31] == y[31]) r = {1'b0, big} + {1'b0, small_sh};
    else                r = {1'b0, big} - {1'b0, small_sh};
    if (r == 28'd0) return {x[31] & y[31], 31'd0};
    e = {2'b00, ex};
    if (r[27]) begin
      r = {1'b0, r[27:2], r[1] | r[0]};
      e = e + 10'd1;
    end else begin
      for (int i = 0; i < 26; i++) begin
        if (!r[26] && e > 10'd1) begin
          r = r << 1;
          e = e - 10'd1;
        end
      end
    end
    rnd = r[2] && (r[1] || r[0] || r[3]);
    m   = {1'b0, r[26:3]} + {24'd0, rnd};
    if (m[24]) begin
      m = m >> 1;
      e = e + 10'd1;
    end
    if (e >= 10'd255) return {x[31], 8'hFF, 23'd0};
    return {x[31], m[23] ? e[7:0] : 8'd0, m[22:0]};
  endfunction

  // Strict single-precision less-than; any NaN operand yields 0.
  function automatic logic fp_lt(input logic [31:0] a, input logic [31:0] b);
    if (a[30:23] == 8'hFF && a[22:0] != 23'd0) return 1'b0;
    if (b[30:23] == 8'hFF && b[22:0] != 23'd0) return 1'b0;
    if (a[30:0] == 31'd0 && b[30:0] == 31'd0) return 1'b0;
    if (a[31] != b[31]) return a[31];
    if (!a[31]) return a[30:0] < b[30:0];
    return a[30:0] > b[30:0];
  endfunction

  state_t                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] src_q, src_d;
  logic [INDEX_WIDTH-1:0] tgt_q, tgt_d;
  logic [INDEX_WIDTH-1:0] u_q, u_d;
  logic [VALUE_WIDTH-1:0] du_q, du_d;
  logic [INDEX_WIDTH-1:0] j_q, j_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   wait_first_q, wait_first_d;
  logic                   unreachable_q, unreachable_d;
  logic [VALUE_WIDTH-1:0] dist_q [MAX_NODES];
  logic [VALUE_WIDTH-1:0] dist_d [MAX_NODES];
  logic [MAX_NODES-1:0]   visited_q, visited_d;
  logic [INDEX_WIDTH-1:0] prev_q [MAX_NODES];
  logic [INDEX_WIDTH-1:0] prev_d [MAX_NODES];

  logic                   src_ok, tgt_ok;
  logic [VALUE_WIDTH-1:0] relax_sum;
  logic                   relax_ok;

  // Indices are zero-extended so a non-power-of-two node count is still guarded.
  assign src_ok = (32'(source_index) < MAX_NODES);
  assign tgt_ok = (32'(target_index) < MAX_NODES);

  assign relax_sum = fp_add(du_q, adj_rd_data);
  assign relax_ok  = (j_q != u_q) && !visited_q[j_q] && (adj_rd_data != INF) &&
                     fp_lt(relax_sum, dist_q[j_q]);

  // Next-state and datapath update for the search sequencer.
  always_comb begin
    state_d       = state_q;
    src_d         = src_q;
    tgt_d         = tgt_q;
    u_d           = u_q;
    du_d          = du_q;
    j_d           = j_q;
    cnt_d         = cnt_q;
    wait_first_d  = wait_first_q;
    unreachable_d = unreachable_q;
    dist_d        = dist_q;
    visited_d     = visited_q;
    prev_d        = prev_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (src_ok && tgt_ok) begin
            src_d         = source_index;
            tgt_d         = target_index;
            unreachable_d = 1'b0;
            state_d       = ST_INIT;
          end else begin
            unreachable_d = 1'b1;
            state_d       = ST_DONE;
          end
        end
      end
      ST_INIT: begin
        for (int k = 0; k < MAX_NODES; k++) begin
          dist_d[k] = (INDEX_WIDTH'(k) == src_q) ? '0 : INF;
          prev_d[k] = INDEX_WIDTH'(k);
        end
        visited_d    = '0;
        wait_first_d = 1'b1;
        state_d      = ST_WAIT_MIN;
      end
      ST_WAIT_MIN: begin
        // The heap's ready flag may still be stale in the first cycle.
        wait_first_d = 1'b0;
        if (!wait_first_q && min_ready) begin
          cnt_d   = CNT_WIDTH'(SETTLE_CYCLES);
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (!min_ready)          state_d = ST_WAIT_MIN;
        else if (cnt_q == '0)    state_d = ST_SELECT;
        else                     cnt_d   = cnt_q - CNT_WIDTH'(1);
      end
      ST_SELECT: begin
        u_d  = min_index;
        du_d = min_value;
        if (min_value == INF || visited_q[min_index]) begin
          unreachable_d = ~visited_q[tgt_q];
          state_d       = ST_DONE;
        end else begin
          visited_d[min_index] = 1'b1;
          if (min_index == tgt_q) begin
            unreachable_d = 1'b0;
            state_d       = ST_DONE;
          end else begin
            j_d     = '0;
            state_d = ST_READ;
          end
        end
      end
      ST_READ: begin
        state_d = ST_RELAX;
      end
      ST_RELAX: begin
        if (relax_ok) begin
          dist_d[j_q] = relax_sum;
          prev_d[j_q] = u_q;
        end
        if (j_q == LAST_NODE) begin
          state_d = ST_NOTIFY;
        end else begin
          j_d     = j_q + INDEX_WIDTH'(1);
          state_d = ST_READ;
        end
      end
      ST_NOTIFY: begin
        wait_first_d = 1'b1;
        state_d      = ST_WAIT_MIN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset discards any update computed in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      src_q         <= '0;
      tgt_q         <= '0;
      u_q           <= '0;
      du_q          <= '0;
      j_q           <= '0;
      cnt_q         <= '0;
      wait_first_q  <= 1'b0;
      unreachable_q <= 1'b0;
      visited_q     <= '0;
      for (int k = 0; k < MAX_NODES; k++) begin
        dist_q[k] <= INF;
        prev_q[k] <= '0;
      end
    end else begin
      state_q       <= state_d;
      src_q         <= src_d;
      tgt_q         <= tgt_d;
      u_q           <= u_d;
      du_q          <= du_d;
      j_q           <= j_d;
      cnt_q         <= cnt_d;
      wait_first_q  <= wait_first_d;
      unreachable_q <= unreachable_d;
      visited_q     <= visited_d;
      dist_q        <= dist_d;
      prev_q        <= prev_d;
    end
  end

  assign adj_rd_en         = (state_q == ST_READ);
  assign adj_addr          = (state_q == ST_READ) ? {u_q, j_q} : '0;
  assign set_en            = (state_q == ST_INIT);
  assign visit_vector_true = (state_q == ST_NOTIFY);
  assign busy              = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done              = (state_q == ST_DONE);
  assign unreachable       = unreachable_q;
  assign dist_vector       = dist_q;
  assign visited_vector    = visited_q;
  assign prev_vector       = prev_q;

endmodule
`default_nettype wire
